dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory port.
- Accepts load/store requests (word address, write data, byte-lane write enables, ld/str strobes), inserts a configurable number of wait states, then completes each request with a one-cycle response.
- Drives busy back to the pipeline so the core can hold its memory stage, and flags malformed requests with err.
- Replaces the zero-latency datamemory model for multi-cycle memory bring-up.

Parameters:
ADDR_W, 12, word-address width (matches core's alu_o[13:2] slice)
DEPTH, 4096, number of 32-bit words implemented; must be <= 2**ADDR_W
WAIT_CYCLES, 1, wait states between acceptance and response; legal range 0..15

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
adr  input  ADDR_W  word address of request
data_in  input  32  store data, byte i on bits [8i+7:8i]
WE  input  4  byte-lane write enables for stores
ld  input  1  load request strobe
str  input  1  store request strobe
data_out  output  32  load data, valid when rsp_valid=1 for a load
rsp_valid  output  1  one-cycle completion pulse
busy  output  1  responder not accepting; core must hold request
err  output  1  one-cycle error flag, coincident with rsp_valid

Behaviour:
- One clock domain (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, wait counter=0, data_out=0, rsp_valid=0, busy=0, err=0. Memory contents are not cleared by reset; optional preload is simulation-only.
- States: IDLE, WAIT, RESP. busy = (state != IDLE), registered.
- Acceptance: in IDLE with (ld | str)=1 at a rising edge, the request is accepted.
  - adr, data_in, WE and the request kind are latched.
  - Next state is WAIT if WAIT_CYCLES > 0, else RESP.
- Requests presented while busy=1 are ignored; inputs need not be stable after acceptance.
- WAIT: counter loads WAIT_CYCLES-1 on entry and decrements each cycle; it transitions to RESP when the counter = 0.
- RESP: exactly one cycle with rsp_valid=1, then unconditional return to IDLE.
- Latency: request accepted at edge T, so rsp_valid is high in cycle T+1+WAIT_CYCLES. Back-to-back throughput is one request per WAIT_CYCLES+2 cycles; the next request can be accepted at the edge ending RESP+1 (first IDLE cycle).
- Loads: in RESP, data_out = mem[latched adr] (full 32-bit word, no extension; the core performs sign/zero extension). data_out holds its value until the next successful load response; it is not updated by stores or errors.
- Stores: the write commits at the rising edge that ends the RESP cycle. Byte i is written iff latched WE[i]=1. Store with WE=4'b0000 completes normally with no write.
- Read-after-write: a load accepted in the IDLE cycle following a store's RESP returns the new data.
- Error cases, both flagged as err=1 in the RESP cycle with rsp_valid=1, no memory write, and data_out unchanged. They still take full latency.
  - ld=1 and str=1 together at acceptance.
  - Latched adr >= DEPTH.
- Reset mid-operation (WAIT or RESP): return to IDLE, pending store discarded, no response issued, outputs to reset values.
- Idle inputs (ld=str=0) leave all state unchanged.

Test Plan:
- Reset then idle: assert reset 2 cycles with ld=str=0 -> busy=0, rsp_valid=0, err=0, data_out=0; no state change for 10 idle cycles.
- Store/load word, WAIT_CYCLES=1:
  - Store adr=12'h010, data_in=32'hDEADBEEF, WE=4'hF at edge T -> busy=1 at T+1..T+2, rsp_valid=1 only in cycle T+2.
  - Then load adr=12'h010 -> rsp_valid after 2 cycles with data_out=32'hDEADBEEF, err=0.
- Byte lanes:
  - Preload adr 12'h020 with 32'h11223344, then store data_in=32'hAABBCCDD with WE=4'b0010.
  - Load adr 12'h020 -> data_out=32'h1122CC44.
  - Store with WE=0 -> word unchanged, rsp_valid=1, err=0.
- Errors:
  - ld=str=1 -> err=1 with rsp_valid, memory unchanged.
  - With DEPTH=1024, load adr=12'h400 -> err=1, data_out retains previous value.
- Busy hold and zero wait:
  - WAIT_CYCLES=0: load accepted at T, rsp_valid in T+1.
  - A second request held during busy is accepted only at the first IDLE edge, giving rsp_valid at T+3.
  - WAIT_CYCLES=15: rsp_valid exactly 16 cycles after acceptance.
- Reset mid-op: store adr=12'h030 data 32'h5A5A5A5A, assert reset during WAIT -> no rsp_valid, busy=0 next cycle; subsequent load of 12'h030 returns the original contents.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store at a time, waits
// WAIT_CYCLES, then completes with a one-cycle rsp_valid (and err for bad requests).
module dmem_responder #(
    parameter int ADDR_W      = 12,
    parameter int DEPTH       = 4096,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] adr,
    input  logic [31:0]       data_in,
    input  logic [3:0]        WE,
    input  logic              ld,
    input  logic              str,
    output logic [31:0]       data_out,
    output logic              rsp_valid,
    output logic              busy,
    output logic              err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state;
    logic [3:0]       cnt;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      wdata_q;
    logic [3:0]       we_q;
    logic             is_ld_q;
    logic             bad_q;

    logic [31:0] mem [DEPTH];

    logic             req;
    logic             bad_in;
    logic             go_resp;
    logic             resp_ld;
    logic             resp_err;
    logic [IDX_W-1:0] rd_idx;

    assign req    = ld | str;
    assign bad_in = (ld & str) | (32'(adr) >= 32'(DEPTH));

    // With zero wait states the response is launched straight from IDLE, so the
    // read and error paths take the live request instead of the latched one.
    always_comb begin
        go_resp  = 1'b0;
        resp_ld  = is_ld_q;
        resp_err = bad_q;
        rd_idx   = idx_q;
        if (state == IDLE) begin
            go_resp  = req && (WAIT_CYCLES == 0);
            resp_ld  = ld & ~str;
            resp_err = bad_in;
            rd_idx   = adr[IDX_W-1:0];
        end else if (state == WAIT) begin
            go_resp  = (cnt == 4'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            data_out  <= 32'd0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= 32'd0;
            we_q      <= 4'd0;
            is_ld_q   <= 1'b0;
            bad_q     <= 1'b0;
        end else begin
            rsp_valid <= go_resp;
            err       <= go_resp & resp_err;
            if (go_resp && resp_ld && !resp_err)
                data_out <= mem[rd_idx];

            case (state)
                IDLE: begin
                    if (req) begin
                        idx_q   <= adr[IDX_W-1:0];
                        wdata_q <= data_in;
                        we_q    <= WE;
                        is_ld_q <= ld & ~str;
                        bad_q   <= bad_in;
                        cnt     <= 4'(WAIT_CYCLES - 1);
                        state   <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                        busy    <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0)
                        state <= RESP;
                    else
                        cnt <= cnt - 4'd1;
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Store commits on the edge that ends RESP; a reset on that edge drops it.
    always_ff @(posedge clk) begin
        if (!reset && state == RESP && !is_ld_q && !bad_q) begin
            for (int b = 0; b < 4; b++)
                if (we_q[b])
                    mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (WAIT 1/DEPTH 1024,
// WAIT 0, WAIT 15), directed cases then randomized traffic vs a word-array model.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]  ld, str, rsp_valid, busy, err;
    logic [11:0] adr  [3];
    logic [31:0] din  [3];
    logic [31:0] dout [3];
    logic [3:0]  we   [3];

    dmem_responder #(.ADDR_W(12), .DEPTH(1024), .WAIT_CYCLES(1)) u0 (
        .clk(clk), .reset(reset), .adr(adr[0]), .data_in(din[0]), .WE(we[0]),
        .ld(ld[0]), .str(str[0]), .data_out(dout[0]), .rsp_valid(rsp_valid[0]),
        .busy(busy[0]), .err(err[0]));
    dmem_responder #(.ADDR_W(12), .DEPTH(4096), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .reset(reset), .adr(adr[1]), .data_in(din[1]), .WE(we[1]),
        .ld(ld[1]), .str(str[1]), .data_out(dout[1]), .rsp_valid(rsp_valid[1]),
        .busy(busy[1]), .err(err[1]));
    dmem_responder #(.ADDR_W(12), .DEPTH(4096), .WAIT_CYCLES(15)) u2 (
        .clk(clk), .reset(reset), .adr(adr[2]), .data_in(din[2]), .WE(we[2]),
        .ld(ld[2]), .str(str[2]), .data_out(dout[2]), .rsp_valid(rsp_valid[2]),
        .busy(busy[2]), .err(err[2]));

    typedef struct {
        int          inst;
        int          cyc;
        bit          err;
        bit          chk;
        logic [31:0] data;
    } exp_t;

    exp_t      sbq[$];
    int        total = 0;
    int        bad = 0;
    int        cyc = 0;
    bit [31:0] mem_m   [3][4096];
    bit        known_m [3][4096];
    bit [31:0] dout_m  [3];
    bit        dknown  [3];
    bit        in_flight [3];
    int        done_cyc  [3];

    function automatic int wc(int i);
        return (i == 0) ? 1 : ((i == 1) ? 0 : 15);
    endfunction

    function automatic int dp(int i);
        return (i == 0) ? 1024 : 4096;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the expected response whenever any instance completes.
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("busy%0d", i), 32'(busy[i]),
                    32'(in_flight[i] && cyc <= done_cyc[i]));
                if (rsp_valid[i]) begin
                    if (sbq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_rsp inst %0d: got rsp_valid=1 want 0", i);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        chk("rsp_inst", 32'(i), 32'(e.inst));
                        chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
                        chk("rsp_err", 32'(err[i]), 32'(e.err));
                        if (e.chk) chk("rsp_data", dout[i], e.data);
                    end
                end else if (err[i]) begin
                    chk("err_without_rsp", 32'(err[i]), 32'd0);
                end
            end
        end
    end

    task automatic issue(int i, bit l, bit s, logic [11:0] a, logic [31:0] d,
                         logic [3:0] w, bit garbage, bit push, output int acc);
        bit b;
        bit ok;
        bit errv;
        int n;
        exp_t e;
        ok = 0;
        n  = 0;
        @(negedge clk);
        ld[i] = l; str[i] = s; adr[i] = a; din[i] = d; we[i] = w;
        while (!ok && n < 100) begin
            b = busy[i];
            @(posedge clk);
            #1;
            if (!b) ok = 1;
            else begin
                n++;
                @(negedge clk);
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout inst %0d: got busy=1 want 0", i);
            ld[i] = 1'b0; str[i] = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc;
        in_flight[i] = 1'b1;
        done_cyc[i]  = cyc + wc(i);
        if (push) begin
            errv = (l && s) || (int'(a) >= dp(i));
            if (!errv && s) begin
                for (int k = 0; k < 4; k++)
                    if (w[k]) mem_m[i][a][8*k +: 8] = d[8*k +: 8];
                if (w == 4'hF) known_m[i][a] = 1'b1;
            end
            if (!errv && l) begin
                dout_m[i] = mem_m[i][a];
                dknown[i] = known_m[i][a];
            end
            e.inst = i; e.cyc = cyc + wc(i); e.err = errv;
            e.chk = dknown[i]; e.data = dout_m[i];
            sbq.push_back(e);
        end
        // Junk while busy must be ignored; removed before the first IDLE edge.
        if (garbage) begin
            ld[i] = 1'b1; str[i] = 1'($urandom); adr[i] = 12'($urandom);
            din[i] = $urandom; we[i] = 4'($urandom);
            @(posedge clk);
            #1;
        end
        ld[i] = 1'b0; str[i] = 1'b0;
    endtask

    task automatic wait_rsp(int i, output int rc);
        rc = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rsp_valid[i]) begin
                rc = cyc;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL rsp_timeout inst %0d: got no rsp_valid want one", i);
    endtask

    initial begin
        int a1, a2, rc;
        int base, nops;
        logic [11:0] ra;
        ld = '0; str = '0;
        for (int i = 0; i < 3; i++) begin
            adr[i] = '0; din[i] = '0; we[i] = '0;
            dout_m[i] = '0; dknown[i] = 1'b1; in_flight[i] = 1'b0; done_cyc[i] = 0;
        end

        // Reset and idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("reset_busy", 32'(busy[i]), 32'd0);
            chk("reset_rsp", 32'(rsp_valid[i]), 32'd0);
            chk("reset_err", 32'(err[i]), 32'd0);
            chk("reset_dout", dout[i], 32'd0);
        end
        repeat (10) @(negedge clk);
        for (int i = 0; i < 3; i++) chk("idle_dout", dout[i], 32'd0);

        // Word store/load with one wait state; explicit busy/rsp timing
        issue(0, 0, 1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 1, a1);
        @(negedge clk);
        chk("w1_busy_T1", 32'(busy[0]), 32'd1);
        chk("w1_rsp_T1", 32'(rsp_valid[0]), 32'd0);
        @(negedge clk);
        chk("w1_busy_T2", 32'(busy[0]), 32'd1);
        chk("w1_rsp_T2", 32'(rsp_valid[0]), 32'd1);
        @(negedge clk);
        chk("w1_busy_T3", 32'(busy[0]), 32'd0);
        chk("w1_rsp_T3", 32'(rsp_valid[0]), 32'd0);
        issue(0, 1, 0, 12'h010, 32'h0, 4'h0, 0, 1, a1);
        wait_rsp(0, rc);
        chk("load_word", dout[0], 32'hDEADBEEF);

        // Byte lanes, empty WE, both strobes, out-of-range address
        issue(0, 0, 1, 12'h020, 32'h11223344, 4'hF, 0, 1, a1);
        issue(0, 0, 1, 12'h020, 32'hAABBCCDD, 4'b0010, 0, 1, a1);
        issue(0, 1, 0, 12'h020, 32'h0, 4'h0, 0, 1, a1);
        wait_rsp(0, rc);
        chk("byte_lane", dout[0], 32'h1122CC44);
        issue(0, 0, 1, 12'h020, 32'hFFFFFFFF, 4'h0, 0, 1, a1);
        wait_rsp(0, rc);
        chk("we0_err", 32'(err[0]), 32'd0);
        issue(0, 1, 1, 12'h020, 32'h01010101, 4'hF, 0, 1, a1);
        wait_rsp(0, rc);
        chk("both_err", 32'(err[0]), 32'd1);
        issue(0, 1, 0, 12'h020, 32'h0, 4'h0, 0, 1, a1);
        wait_rsp(0, rc);
        chk("after_we0_both", dout[0], 32'h1122CC44);
        issue(0, 1, 0, 12'h400, 32'h0, 4'h0, 0, 1, a1);
        wait_rsp(0, rc);
        chk("oor_err", 32'(err[0]), 32'd1);
        chk("oor_dout_held", dout[0], 32'h1122CC44);

        // Zero wait states; second request held during busy
        issue(1, 0, 1, 12'h005, 32'hCAFEF00D, 4'hF, 0, 1, a1);
        issue(1, 1, 0, 12'h005, 32'h0, 4'h0, 0, 1, a2);
        chk("hold_accept", 32'(a2), 32'(a1 + 2));
        wait_rsp(1, rc);
        chk("w0_raw", dout[1], 32'hCAFEF00D);
        chk("w0_lat", 32'(rc - a2), 32'd0);

        // Fifteen wait states
        issue(2, 0, 1, 12'h030, 32'h13579BDF, 4'hF, 0, 1, a1);
        wait_rsp(2, rc);
        issue(2, 1, 0, 12'h030, 32'h0, 4'h0, 0, 1, a1);
        wait_rsp(2, rc);
        chk("w15_lat", 32'(rc - a1), 32'd15);
        chk("w15_data", dout[2], 32'h13579BDF);

        // Reset during WAIT drops the store
        issue(2, 0, 1, 12'h030, 32'h5A5A5A5A, 4'hF, 0, 0, a1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            in_flight[i] = 1'b0; dout_m[i] = '0; dknown[i] = 1'b1;
        end
        chk("rst_busy", 32'(busy[2]), 32'd0);
        chk("rst_rsp", 32'(rsp_valid[2]), 32'd0);
        chk("rst_dout", dout[2], 32'd0);
        @(negedge clk);
        reset = 1'b0;
        issue(2, 1, 0, 12'h030, 32'h0, 4'h0, 0, 1, a1);
        wait_rsp(2, rc);
        chk("rst_store_dropped", dout[2], 32'h13579BDF);

        // Randomized traffic on every instance
        for (int i = 0; i < 3; i++) begin
            base = (i == 0) ? 'h3F8 : 'h100;
            for (int k = 0; k < 16; k++)
                issue(i, 0, 1, 12'(base + k), $urandom, 4'hF, 0, 1, a1);
            nops = (i == 2) ? 15 : 40;
            for (int k = 0; k < nops; k++) begin
                int kind;
                kind = int'($urandom_range(0, 9));
                ra = 12'(base + int'($urandom_range(0, 15)));
                if (kind < 4)
                    issue(i, 1, 0, ra, $urandom, 4'($urandom), 1'($urandom), 1, a1);
                else if (kind < 9)
                    issue(i, 0, 1, ra, $urandom, 4'($urandom), 1'($urandom), 1, a1);
                else
                    issue(i, 1, 1, ra, $urandom, 4'($urandom), 1'($urandom), 1, a1);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        repeat (25) @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
